// File: rtl/bit_brick_if.sv
// bit_brick operand/product bundle.
// The master drives the operands and sign flags and reads back the registered product.
interface bit_brick_if;
  logic [1:0] x;
  logic [1:0] y;
  logic       sign_x;
  logic       sign_y;
  logic [5:0] p;

  modport master (output x, output y, output sign_x, output sign_y, input p);
  modport slave  (input x, input y, input sign_x, input sign_y, output p);
endinterface

// File: rtl/bit_brick.sv
// bit_brick: registered 2x2 multiplier cell with per-operand signedness.
// Each operand is extended to 3 bits (sign bit = flag & msb) and multiplied with
// an explicit Baugh-Wooley partial-product array; the 6-bit two's-complement
// product is registered.
// Optional macro BIT_BRICK_IN_REG_EN adds an input register stage (2-cycle latency);
// without it the product register is fed combinationally (1-cycle latency).
module bit_brick (
  input  logic        clk,
  input  logic        reset,
  bit_brick_if.slave  bb
);

  logic [1:0] x_s;
  logic [1:0] y_s;
  logic       sx_s;
  logic       sy_s;

`ifdef BIT_BRICK_IN_REG_EN
  // Input capture stage; reset clears it so the first product after reset is 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_s  <= 2'b00;
      y_s  <= 2'b00;
      sx_s <= 1'b0;
      sy_s <= 1'b0;
    end else begin
      x_s  <= bb.x;
      y_s  <= bb.y;
      sx_s <= bb.sign_x;
      sy_s <= bb.sign_y;
    end
  end
`else
  assign x_s  = bb.x;
  assign y_s  = bb.y;
  assign sx_s = bb.sign_x;
  assign sy_s = bb.sign_y;
`endif

  logic [2:0] a;
  logic [2:0] b;
  logic [5:0] row0;
  logic [5:0] row1;
  logic [5:0] row2;
  logic [5:0] sum01;
  logic [5:0] sum2c;
  logic [5:0] p_next;
  logic [5:0] p_q;

  // Baugh-Wooley array: terms mixing a sign bit with a magnitude bit are inverted,
  // and the resulting -24 offset is folded into the constant 6'b101000 (40 = -24 mod 64).
  always_comb begin
    a      = {sx_s & x_s[1], x_s};
    b      = {sy_s & y_s[1], y_s};
    row0   = {1'b0, a[2] & b[2], ~(a[2] & b[1]), a[1] & b[1], a[1] & b[0], a[0] & b[0]};
    row1   = {2'b00, ~(a[1] & b[2]), ~(a[2] & b[0]), a[0] & b[1], 1'b0};
    row2   = {3'b000, ~(a[0] & b[2]), 2'b00};
    sum01  = row0 + row1;
    sum2c  = row2 + 6'b101000;
    p_next = sum01 + sum2c;
  end

  // Product register; reset has priority over data.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_q <= 6'b000000;
    end else begin
      p_q <= p_next;
    end
  end

  assign bb.p = p_q;

endmodule

// File: tb/tb_bit_brick.sv
// Self-checking bench for bit_brick: directed vectors with hand-computed products,
// then an exhaustive back-to-back stream with a mid-stream reset.
module tb_bit_brick;

`ifdef BIT_BRICK_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bit_brick_if bb ();

  bit_brick dut (
    .clk   (clk),
    .reset (reset),
    .bb    (bb)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [5:0] stage_m = 6'b000000;

  task automatic check_val(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (6'b%b) expected %0d (6'b%b)", tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  function automatic logic [5:0] ref_mul(input logic [1:0] xv, input logic [1:0] yv,
                                         input logic sxv, input logic syv);
    int xi;
    int yi;
    xi = (sxv && xv[1]) ? int'(xv) - 4 : int'(xv);
    yi = (syv && yv[1]) ? int'(yv) - 4 : int'(yv);
    return 6'(xi * yi);
  endfunction

  task automatic drive(input logic [1:0] xv, input logic [1:0] yv,
                       input logic sxv, input logic syv, input logic rst);
    bb.x      = xv;
    bb.y      = yv;
    bb.sign_x = sxv;
    bb.sign_y = syv;
    reset     = rst;
  endtask

  task automatic hold_check(input string tag, input logic [1:0] xv, input logic [1:0] yv,
                            input logic sxv, input logic syv, input logic [5:0] exp);
    drive(xv, yv, sxv, syv, 1'b0);
    repeat (LAT) @(posedge clk);
    #1;
    check_val(tag, bb.p, exp);
  endtask

  task automatic step(input logic [1:0] xv, input logic [1:0] yv,
                      input logic sxv, input logic syv, input logic rst, input string tag);
    logic [5:0] exp;
    drive(xv, yv, sxv, syv, rst);
    if (LAT == 1) begin
      exp = rst ? 6'b000000 : ref_mul(xv, yv, sxv, syv);
    end else begin
      exp     = rst ? 6'b000000 : stage_m;
      stage_m = rst ? 6'b000000 : ref_mul(xv, yv, sxv, syv);
    end
    @(posedge clk);
    #1;
    check_val(tag, bb.p, exp);
  endtask

  initial begin
    logic [7:0] v;

    drive(2'b11, 2'b11, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check_val("reset_p", bb.p, 6'b000000);
    hold_check("reset_release_9", 2'b11, 2'b11, 1'b0, 1'b0, 6'b001001);

    hold_check("uu_0x0", 2'b00, 2'b00, 1'b0, 1'b0, 6'b000000);
    hold_check("uu_1x0", 2'b01, 2'b00, 1'b0, 1'b0, 6'b000000);
    hold_check("uu_0x1", 2'b00, 2'b01, 1'b0, 1'b0, 6'b000000);
    hold_check("uu_1x1", 2'b01, 2'b01, 1'b0, 1'b0, 6'b000001);

    hold_check("su_m2x3", 2'b10, 2'b11, 1'b1, 1'b0, 6'b111010);
    hold_check("us_3xm2", 2'b11, 2'b10, 1'b0, 1'b1, 6'b111010);

    hold_check("uu_3x3", 2'b11, 2'b11, 1'b0, 1'b0, 6'b001001);
    hold_check("ss_m1xm1", 2'b11, 2'b11, 1'b1, 1'b1, 6'b000001);
    hold_check("ss_m2xm2", 2'b10, 2'b10, 1'b1, 1'b1, 6'b000100);
    hold_check("su_m1x3", 2'b11, 2'b11, 1'b1, 1'b0, 6'b111101);

    step(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, "exh_reset");
    for (int i = 0; i < 256; i++) begin
      v = 8'(i);
      if (i == 100) begin
        step(2'b11, 2'b11, 1'b1, 1'b0, 1'b1, "exh_mid_reset");
      end
      step(v[1:0], v[3:2], v[4], v[5], 1'b0, $sformatf("exh_%0d", i));
    end
    for (int k = 0; k < 2; k++) begin
      step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, $sformatf("exh_flush_%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
